// File: rtl/uart_rx_buffered.sv
// UART receiver with 2-flop input synchroniser, configurable framing, error
// pulses and a first-word fall-through receive FIFO behind a valid/ready port.
module uart_rx_buffered #(
   parameter int unsigned CLK_FREQ   = 100000000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          rx,
   input  logic                          rx_en,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          clr_overrun,
   output logic                          busy
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PW           = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW         = PW + 1;

   localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   HALF_LAST = CW'(HALF_BIT - 1);
   localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic            PAR_ODD   = (PARITY == 1);
   localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                 state_q;
   logic                   s1_q, s2_q, rx_prev_q;
   logic [CW-1:0]          clk_cnt_q;
   logic [3:0]             bit_cnt_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   perr_q, ferr_q;
   logic                   parity_err_q, frame_err_q, overrun_q;

   logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0]        count_q;

   logic bit_tick, last_stop, ferr_d, good_frame, fifo_nempty, pop, push, drop;

   always_comb begin
      bit_tick    = (clk_cnt_q == BIT_LAST);
      last_stop   = (state_q == S_STOP) && bit_tick && (bit_cnt_q == STOP_LAST);
      ferr_d      = ferr_q | ~s2_q;
      good_frame  = last_stop && !ferr_d && !perr_q;
      fifo_nempty = (count_q != '0);
      pop         = fifo_nempty && rd_ready;
      push        = good_frame && ((count_q < DEPTH_C) || pop);
      drop        = good_frame && !push;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         s1_q         <= 1'b1;
         s2_q         <= 1'b1;
         rx_prev_q    <= 1'b1;
         clk_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         s1_q         <= rx;
         s2_q         <= s1_q;
         rx_prev_q    <= s2_q;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         if (drop)
            overrun_q <= 1'b1;
         else if (clr_overrun)
            overrun_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               clk_cnt_q <= '0;
               if (rx_en && rx_prev_q && !s2_q)
                  state_q <= S_START;
            end
            S_START: begin
               if (clk_cnt_q == HALF_LAST) begin
                  clk_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  state_q   <= s2_q ? S_IDLE : S_DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
            S_DATA: begin
               if (bit_tick) begin
                  clk_cnt_q <= '0;
                  // LSB arrives first: shifting in at the MSB leaves bit k at k after the last sample
                  shift_q   <= {s2_q, shift_q[DATA_BITS-1:1]};
                  if (bit_cnt_q == DATA_LAST) begin
                     bit_cnt_q <= '0;
                     perr_q    <= 1'b0;
                     ferr_q    <= 1'b0;
                     state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
            S_PARITY: begin
               if (bit_tick) begin
                  clk_cnt_q <= '0;
                  perr_q    <= (^{shift_q, s2_q}) != PAR_ODD;
                  state_q   <= S_STOP;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
            S_STOP: begin
               if (bit_tick) begin
                  clk_cnt_q <= '0;
                  ferr_q    <= ferr_d;
                  if (bit_cnt_q == STOP_LAST) begin
                     state_q      <= S_IDLE;
                     frame_err_q  <= ferr_d;
                     parity_err_q <= !ferr_d && perr_q;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNTW'(1);
            2'b01:   count_q <= count_q - CNTW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= shift_q;
   end

   assign rd_data    = mem_q[rd_ptr_q];
   assign rd_valid   = fifo_nempty;
   assign fifo_count = count_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: 8E1 framing, 4-deep FIFO, 16 clk/bit.
module tb_uart_rx_buffered;

   localparam int CPB         = 16;
   localparam int HALF        = CPB / 2;
   localparam int DB          = 8;
   localparam int PAR         = 2;
   localparam int SB          = 1;
   localparam int DEPTH       = 4;
   localparam int FRAME_BITS  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
   // Cycles from the first low s2 cycle to the cycle of the last stop sample
   localparam int LAST_SAMPLE = HALF + (FRAME_BITS - 1) * CPB;

   logic          clk = 1'b0;
   logic          reset_n, rx, rx_en, rd_ready, clr_overrun;
   logic [DB-1:0] rd_data;
   logic          rd_valid, parity_err, frame_err, overrun, busy;
   logic [2:0]    fifo_count;

   always #5 clk = ~clk;

   uart_rx_buffered #(
      .CLK_FREQ   (1600),
      .BAUD_RATE  (100),
      .DATA_BITS  (DB),
      .PARITY     (PAR),
      .STOP_BITS  (SB),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rx          (rx),
      .rx_en       (rx_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .fifo_count  (fifo_count),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .clr_overrun (clr_overrun),
      .busy        (busy)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DB-1:0] exp_q[$];
   int            pe_exp = 0, fe_exp = 0, pe_seen = 0, fe_seen = 0;
   logic          ovr_exp = 1'b0;
   bit            rand_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic par_bit(input logic [DB-1:0] d);
      return (PAR == 1) ? ~(^d) : (^d);
   endfunction

   // Reference model: decides the fate of a frame from its contents and FIFO occupancy
   task automatic expect_frame(input logic [DB-1:0] d, input bit bad_par, input bit bad_stop,
                               input bit pop_on_push);
      if (bad_stop)
         fe_exp++;
      else if (bad_par)
         pe_exp++;
      else if (exp_q.size() < DEPTH || pop_on_push)
         exp_q.push_back(d);
      else
         ovr_exp = 1'b1;
   endtask

   task automatic tick_neg();
      @(negedge clk);
      if (rand_ready)
         rd_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (CPB) tick_neg();
   endtask

   task automatic send_frame(input logic [DB-1:0] d, input bit bad_par, input bit bad_stop);
      drive_bit(1'b0);
      for (int i = 0; i < DB; i++)
         drive_bit(d[i]);
      if (PAR != 0)
         drive_bit(par_bit(d) ^ bad_par);
      for (int i = 0; i < SB; i++)
         drive_bit(bad_stop ? 1'b0 : 1'b1);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick_neg();
   endtask

   // Monitor: pops the scoreboard on every accepted read and counts error pulses
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (reset_n === 1'b1) begin
            if (parity_err) pe_seen++;
            if (frame_err)  fe_seen++;
            if (rd_valid && rd_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_word: got %0h expected none at %0t", rd_data, $time);
               end else begin
                  check("rd_data", rd_data, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int            n;
      bit            found;
      logic [DB-1:0] d;
      int            r;

      rx = 1'b1; rx_en = 1'b1; rd_ready = 1'b0; clr_overrun = 1'b0; reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rd_valid",   rd_valid,   0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_busy",       busy,       0);
      check("rst_parity_err", parity_err, 0);
      check("rst_frame_err",  frame_err,  0);
      check("rst_overrun",    overrun,    0);
      reset_n = 1'b1;
      idle(5);

      // Good frame with latency measurement
      expect_frame(8'h55, 0, 0, 0);
      n = 0; found = 0;
      fork
         send_frame(8'h55, 0, 0);
         begin
            while (!found && n < 400) begin
               @(posedge clk);
               n++;
               @(negedge clk);
               #1;
               if (rd_valid) found = 1;
            end
         end
      join
      check("push_latency", n, 3 + LAST_SAMPLE);
      check("count_after_push", fifo_count, 1);
      rd_ready = 1'b1;
      idle(3);
      check("count_after_pop", fifo_count, 0);

      // Parity
      expect_frame(8'h41, 0, 0, 0);
      send_frame(8'h41, 0, 0);
      idle(4);
      expect_frame(8'h41, 1, 0, 0);
      send_frame(8'h41, 1, 0);
      idle(4);
      check("parity_pulses", pe_seen, pe_exp);
      check("parity_count", fifo_count, 0);

      // Framing error then break
      expect_frame(8'h5A, 0, 1, 0);
      send_frame(8'h5A, 0, 1);
      repeat (3 * CPB) tick_neg();
      check("frame_pulses", fe_seen, fe_exp);
      check("break_busy", busy, 0);
      check("break_count", fifo_count, 0);
      idle(CPB);
      expect_frame(8'hA5, 0, 0, 0);
      send_frame(8'hA5, 0, 0);
      idle(4);
      check("after_break_count", fifo_count, 0);

      // Start-bit glitch
      rx = 1'b0;
      repeat (4) tick_neg();
      check("glitch_busy_high", busy, 1);
      tick_neg();
      idle(2 * CPB);
      check("glitch_busy_low", busy, 0);
      check("glitch_pe", pe_seen, pe_exp);
      check("glitch_fe", fe_seen, fe_exp);
      check("glitch_count", fifo_count, 0);

      // rx_en low blocks start; dropping it mid-frame does not abort
      rx_en = 1'b0;
      send_frame(8'h77, 0, 0);
      idle(4);
      check("rx_en_off_count", fifo_count, 0);
      rx_en = 1'b1;
      expect_frame(8'h3A, 0, 0, 0);
      fork
         send_frame(8'h3A, 0, 0);
         begin
            repeat (5 * CPB) @(negedge clk);
            rx_en = 1'b0;
         end
      join
      idle(4);
      rx_en = 1'b1;

      // Overrun with FIFO full
      rd_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         expect_frame(DB'(i), 0, 0, 0);
         send_frame(DB'(i), 0, 0);
         idle(2);
      end
      check("full_count", fifo_count, DEPTH);
      check("overrun_set", overrun, ovr_exp);
      @(negedge clk) clr_overrun = 1'b1;
      @(negedge clk) clr_overrun = 1'b0;
      ovr_exp = 1'b0;
      check("overrun_clr", overrun, ovr_exp);

      // Full FIFO with a pop on the push cycle accepts the word
      expect_frame(8'h06, 0, 0, 1);
      fork
         send_frame(8'h06, 0, 0);
         begin
            repeat (2 + LAST_SAMPLE) @(posedge clk);
            @(negedge clk) rd_ready = 1'b1;
            @(negedge clk) rd_ready = 1'b0;
         end
      join
      idle(4);
      check("full_pop_count", fifo_count, DEPTH);
      check("full_pop_overrun", overrun, ovr_exp);
      rd_ready = 1'b1;
      idle(8);
      check("drain_count", fifo_count, 0);

      // Asynchronous reset during data bit 3
      rd_ready = 1'b0;
      expect_frame(8'h11, 0, 0, 0);
      send_frame(8'h11, 0, 0);
      idle(4);
      check("pre_reset_count", fifo_count, 1);
      d = 8'h3C;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++)
         drive_bit(d[i]);
      rx = d[3];
      repeat (HALF) tick_neg();
      check("pre_reset_busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      exp_q.delete();
      ovr_exp = 1'b0;
      check("mid_rst_busy",       busy,       0);
      check("mid_rst_rd_valid",   rd_valid,   0);
      check("mid_rst_fifo_count", fifo_count, 0);
      check("mid_rst_parity_err", parity_err, 0);
      check("mid_rst_frame_err",  frame_err,  0);
      check("mid_rst_overrun",    overrun,    0);
      @(negedge clk);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      idle(5);
      rd_ready = 1'b1;
      expect_frame(8'h3C, 0, 0, 0);
      send_frame(8'h3C, 0, 0);
      idle(4);

      // Randomised frames with random consumer back-pressure
      rand_ready = 1'b1;
      for (int k = 0; k < 24; k++) begin
         d = DB'($urandom);
         r = int'($urandom_range(0, 99));
         expect_frame(d, r < 15, r >= 85, 0);
         send_frame(d, r < 15, r >= 85);
         idle(int'($urandom_range(4, 2 * CPB)));
      end
      rand_ready = 1'b0;
      rd_ready   = 1'b1;
      idle(8);

      check("final_drained",  exp_q.size(), 0);
      check("final_pe",       pe_seen, pe_exp);
      check("final_fe",       fe_seen, fe_exp);
      check("final_overrun",  overrun, ovr_exp);
      check("final_count",    fifo_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
